// File: rtl/rc_receiver_multi.sv
`timescale 1ns/1ps
// rc_receiver_multi
// N-channel servo PWM receiver front end. Each pin is synchronized, its high
// time is measured in us_clk ticks (1 us), out-of-range pulses are counted as
// glitches, accepted pulses are clamped and scaled into VAL_WIDTH bits, and a
// per-channel loss-of-signal timer substitutes a failsafe value.
//
// Ports
//   us_clk          1 MHz tick clock, rising edge
//   reset           asynchronous active-high reset
//   pwm_in          raw receiver pins (asynchronous)
//   vals            packed scaled values, channel i at [i*VAL_WIDTH +: VAL_WIDTH]
//   channel_ok      per-channel health (accepted pulse within TIMEOUT_US)
//   failsafe_active registered "any channel unhealthy"
//   frame_valid     one-cycle strobe on an accept of FRAME_CHANNEL
//   glitch_count    saturating count of rejected pulses, all channels
//
// Per-channel pulse FSM
//   state   | meaning
//   ST_IDLE | pin low, waiting for a synchronized rising edge
//   ST_HIGH | pin high, width counter running; falling edge evaluates pulse
module rc_receiver_multi #(
    parameter int unsigned NUM_CHANNELS  = 7,
    parameter int unsigned VAL_WIDTH     = 8,
    parameter int unsigned PULSE_MIN_US  = 1000,
    parameter int unsigned PULSE_MAX_US  = 2000,
    parameter int unsigned GLITCH_MIN_US = 800,
    parameter int unsigned GLITCH_MAX_US = 2500,
    parameter int unsigned SCALE_MUL     = 262,
    parameter int unsigned SCALE_SHIFT   = 10,
    parameter int unsigned TIMEOUT_US    = 25000,
    parameter int unsigned FRAME_CHANNEL = 0,
    parameter logic [NUM_CHANNELS*VAL_WIDTH-1:0] FAILSAFE_VALS =
        {{(NUM_CHANNELS-1){8'd127}}, 8'd0}
) (
    input  logic                              us_clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           pwm_in,
    output logic [NUM_CHANNELS*VAL_WIDTH-1:0] vals,
    output logic [NUM_CHANNELS-1:0]           channel_ok,
    output logic                              failsafe_active,
    output logic                              frame_valid,
    output logic [7:0]                        glitch_count
);

    typedef enum logic {ST_IDLE = 1'b0, ST_HIGH = 1'b1} ch_state_t;

    localparam logic [31:0] VAL_MAX  = (32'd1 << VAL_WIDTH) - 32'd1;
    localparam logic [15:0] CNT_SAT  = 16'hFFFF;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_US - 1);

    ch_state_t [NUM_CHANNELS-1:0]       state;
    logic [NUM_CHANNELS-1:0][15:0]      width_cnt;
    logic [NUM_CHANNELS-1:0][15:0]      tmo_cnt;
    logic [NUM_CHANNELS-1:0]            armed;
    logic [NUM_CHANNELS-1:0]            sync1, sync2, sync3;
    logic [1:0]                         startup_cnt;
    logic                               edge_en;
    logic [NUM_CHANNELS-1:0]            rise, fall, accept, reject;
    logic [NUM_CHANNELS-1:0][VAL_WIDTH-1:0] new_val;
    logic [15:0]                        rej_sum;
    logic [7:0]                         glitch_next;

    function automatic logic [VAL_WIDTH-1:0] scale_width(input logic [15:0] w);
        logic [31:0] wc;
        logic [31:0] prod;
        wc = {16'd0, w};
        if (wc < PULSE_MIN_US)
            wc = PULSE_MIN_US;
        else if (wc > PULSE_MAX_US)
            wc = PULSE_MAX_US;
        prod = ((wc - PULSE_MIN_US) * SCALE_MUL) >> SCALE_SHIFT;
        if (prod > VAL_MAX)
            return VAL_MAX[VAL_WIDTH-1:0];
        return prod[VAL_WIDTH-1:0];
    endfunction

    // The sync chain powers up at 0, so a pin already high at reset release
    // would look like a rising edge. Edges are ignored until the chain holds
    // real pin samples; such a pulse then ends with an unarmed fall.
    assign edge_en = (startup_cnt == 2'd3);
    assign rise    = edge_en ? (sync2 & ~sync3) : '0;
    assign fall    = edge_en ? (~sync2 & sync3) : '0;

    always_comb begin
        accept = '0;
        reject = '0;
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            new_val[i] = scale_width(width_cnt[i]);
            if (fall[i] && (state[i] == ST_HIGH) && armed[i]) begin
                if (({16'd0, width_cnt[i]} >= GLITCH_MIN_US) &&
                    ({16'd0, width_cnt[i]} <= GLITCH_MAX_US))
                    accept[i] = 1'b1;
                else
                    reject[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rej_sum = {8'd0, glitch_count};
        for (int i = 0; i < int'(NUM_CHANNELS); i++)
            rej_sum = rej_sum + {15'd0, reject[i]};
        glitch_next = (rej_sum > 16'd255) ? 8'hFF : rej_sum[7:0];
    end

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            sync1           <= '0;
            sync2           <= '0;
            sync3           <= '0;
            startup_cnt     <= 2'd0;
            state           <= '{default: ST_IDLE};
            width_cnt       <= '0;
            tmo_cnt         <= '0;
            armed           <= '0;
            vals            <= FAILSAFE_VALS;
            channel_ok      <= '0;
            failsafe_active <= 1'b1;
            frame_valid     <= 1'b0;
            glitch_count    <= 8'd0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            sync3 <= sync2;
            if (startup_cnt != 2'd3)
                startup_cnt <= startup_cnt + 2'd1;

            glitch_count    <= glitch_next;
            frame_valid     <= accept[FRAME_CHANNEL];
            failsafe_active <= ~&channel_ok;

            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                case (state[i])
                    ST_IDLE: begin
                        if (rise[i]) begin
                            state[i]     <= ST_HIGH;
                            width_cnt[i] <= 16'd1;
                            armed[i]     <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (fall[i])
                            state[i] <= ST_IDLE;
                        else if (width_cnt[i] != CNT_SAT)
                            width_cnt[i] <= width_cnt[i] + 16'd1;
                    end
                    default: state[i] <= ST_IDLE;
                endcase

                // An accept overrides a timeout landing in the same cycle.
                if (accept[i]) begin
                    tmo_cnt[i]                       <= 16'd0;
                    channel_ok[i]                    <= 1'b1;
                    vals[i*VAL_WIDTH +: VAL_WIDTH]   <= new_val[i];
                end else begin
                    if (tmo_cnt[i] != CNT_SAT)
                        tmo_cnt[i] <= tmo_cnt[i] + 16'd1;
                    if (tmo_cnt[i] == TMO_LAST) begin
                        channel_ok[i]                  <= 1'b0;
                        vals[i*VAL_WIDTH +: VAL_WIDTH] <= FAILSAFE_VALS[i*VAL_WIDTH +: VAL_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rc_receiver_multi.sv
`timescale 1ns/1ps
module tb_rc_receiver_multi;

    localparam int NCH = 7;
    localparam logic [55:0] FS_VALS = {{6{8'd127}}, 8'd0};

    logic           us_clk;
    logic           reset;
    logic [NCH-1:0] pwm_in;
    logic [55:0]    vals;
    logic [NCH-1:0] channel_ok;
    logic           failsafe_active;
    logic           frame_valid;
    logic [7:0]     glitch_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc;
    logic fv_seen;

    rc_receiver_multi dut (
        .us_clk          (us_clk),
        .reset           (reset),
        .pwm_in          (pwm_in),
        .vals            (vals),
        .channel_ok      (channel_ok),
        .failsafe_active (failsafe_active),
        .frame_valid     (frame_valid),
        .glitch_count    (glitch_count)
    );

    initial us_clk = 1'b0;
    always #5 us_clk = ~us_clk;

    always @(posedge us_clk) cyc <= cyc + 1;

    initial begin
        #(1000000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] val_of(input int ch);
        return vals[ch*8 +: 8];
    endfunction

    // Raise the masked pins for 'width' ticks; returns at the drop.
    task automatic drive_pulse(input logic [NCH-1:0] mask, input int width);
        @(negedge us_clk);
        pwm_in = pwm_in | mask;
        repeat (width) @(negedge us_clk);
        pwm_in = pwm_in & ~mask;
    endtask

    // Full pulse; returns once the result is visible on the outputs.
    task automatic pulse(input logic [NCH-1:0] mask, input int width);
        drive_pulse(mask, width);
        repeat (3) @(negedge us_clk);
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = '0;
        repeat (3) @(negedge us_clk);
        check("rst_vals", vals, FS_VALS);
        check("rst_ok", channel_ok, 0);
        check("rst_fsa", failsafe_active, 1);
        check("rst_fv", frame_valid, 0);
        check("rst_glitch", glitch_count, 0);
        reset = 1'b0;
        repeat (50) @(negedge us_clk);
        check("idle_vals", vals, FS_VALS);
        check("idle_ok", channel_ok, 0);
        check("idle_fsa", failsafe_active, 1);

        // ch1: latency and scaling
        drive_pulse(7'h02, 1500);
        repeat (2) @(negedge us_clk);
        check("ch1_ok_early", channel_ok[1], 0);
        @(negedge us_clk);
        check("ch1_ok_lat3", channel_ok[1], 1);
        check("ch1_1500", val_of(1), 127);
        pulse(7'h02, 2000); check("ch1_2000", val_of(1), 255);
        pulse(7'h02, 900);  check("ch1_900", val_of(1), 0);
        pulse(7'h02, 2100); check("ch1_2100", val_of(1), 255);
        pulse(7'h02, 1000); check("ch1_1000", val_of(1), 0);
        pulse(7'h02, 1500); check("ch1_1500b", val_of(1), 127);
        check("ch1_fsa", failsafe_active, 1);

        // ch2 rejects
        pulse(7'h04, 700);
        check("glitch_700", glitch_count, 1);
        check("ch2_val_700", val_of(2), 127);
        check("ch2_ok_700", channel_ok[2], 0);
        pulse(7'h04, 2600);
        check("glitch_2600", glitch_count, 2);
        check("ch2_val_2600", val_of(2), 127);
        pulse(7'h14, 5);
        check("glitch_dual", glitch_count, 4);

        // ch6 glitch window boundaries
        pulse(7'h40, 799);  check("glitch_799", glitch_count, 5);
        check("ch6_ok_799", channel_ok[6], 0);
        pulse(7'h40, 800);  check("ch6_ok_800", channel_ok[6], 1);
        check("ch6_800", val_of(6), 0);
        pulse(7'h40, 2501); check("glitch_2501", glitch_count, 6);
        check("ch6_val_2501", val_of(6), 0);
        pulse(7'h40, 2500); check("ch6_2500", val_of(6), 255);
        check("glitch_2500", glitch_count, 6);

        // saturation
        for (int k = 0; k < 248; k++) pulse(7'h04, 5);
        check("glitch_254", glitch_count, 254);
        pulse(7'h04, 5);
        check("glitch_255", glitch_count, 255);
        pulse(7'h14, 5);
        check("glitch_hold", glitch_count, 255);
        check("ch2_val_sat", val_of(2), 127);

        // timeout on ch3 while the others keep running
        pulse(7'h7F, 1200);
        acc_cyc = cyc;
        check("all_ok", channel_ok, 7'h7F);
        check("ch3_1200", val_of(3), 51);
        @(negedge us_clk);
        check("all_fsa0", failsafe_active, 0);
        repeat (8000) @(negedge us_clk);
        pulse(7'h77, 1200);
        repeat (8000) @(negedge us_clk);
        pulse(7'h77, 1200);
        while (cyc < acc_cyc + 24999) @(negedge us_clk);
        check("tmo_ok_before", channel_ok[3], 1);
        check("tmo_val_before", val_of(3), 51);
        @(negedge us_clk);
        check("tmo_ok", channel_ok[3], 0);
        check("tmo_val", val_of(3), 127);
        check("tmo_others", channel_ok & 7'h77, 7'h77);
        check("tmo_fsa_lag", failsafe_active, 0);
        @(negedge us_clk);
        check("tmo_fsa", failsafe_active, 1);
        pulse(7'h08, 2000);
        check("ch3_restore_ok", channel_ok[3], 1);
        check("ch3_restore_val", val_of(3), 255);
        @(negedge us_clk);
        check("restore_fsa", failsafe_active, 0);

        // frame strobe
        pulse(7'h01, 1000);
        check("ch0_1000", val_of(0), 0);
        drive_pulse(7'h01, 1200);
        @(negedge us_clk); check("fv_n1", frame_valid, 0);
        @(negedge us_clk); check("fv_n2", frame_valid, 0);
        check("ch0_n2", val_of(0), 0);
        @(negedge us_clk); check("fv_n3", frame_valid, 1);
        check("ch0_1200", val_of(0), 51);
        @(negedge us_clk); check("fv_n4", frame_valid, 0);
        drive_pulse(7'h10, 1500);
        fv_seen = 1'b0;
        repeat (6) begin
            @(negedge us_clk);
            fv_seen = fv_seen | frame_valid;
        end
        check("fv_ch4", fv_seen, 0);
        check("ch4_1500", val_of(4), 127);

        // reset mid-pulse, then release with ch5 high
        drive_pulse(7'h02, 100);
        pwm_in = 7'h02;
        repeat (100) @(negedge us_clk);
        reset = 1'b1;
        #1;
        check("mid_rst_vals", vals, FS_VALS);
        check("mid_rst_ok", channel_ok, 0);
        check("mid_rst_fsa", failsafe_active, 1);
        check("mid_rst_glitch", glitch_count, 0);
        pwm_in = 7'h20;
        repeat (4) @(negedge us_clk);
        reset = 1'b0;
        repeat (1500) @(negedge us_clk);
        pwm_in = '0;
        repeat (6) @(negedge us_clk);
        check("ch5_unarmed_glitch", glitch_count, 0);
        check("ch5_unarmed_ok", channel_ok[5], 0);
        check("ch5_unarmed_val", val_of(5), 127);
        pulse(7'h20, 1500);
        check("ch5_first_ok", channel_ok[5], 1);
        check("ch5_first_val", val_of(5), 127);
        pulse(7'h20, 2000);
        check("ch5_2000", val_of(5), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
